// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: size encodings, FSM states and the alignment check shared by the LSU.
package dmem_lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    return (sz == SZ_H && lane[0]) || (sz == SZ_W && lane != 2'd0) || sz == 2'd3;
  endfunction
endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: load lane extract/extend and store lane merge, purely combinational.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_ldata,
  output logic [31:0] o_mdata
);
  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_bmask;
  logic [31:0] w_hmask;
  always_comb begin
    w_bsh   = {i_lane, 3'b000};
    w_hsh   = {i_lane[1], 4'b0000};
    w_byte  = 8'(i_rdata >> w_bsh);
    w_half  = 16'(i_rdata >> w_hsh);
    w_bmask = 32'h0000_00ff << w_bsh;
    w_hmask = 32'h0000_ffff << w_hsh;
    o_ldata = i_size == SZ_B ? {{24{~i_unsigned & w_byte[7]}}, w_byte} :
              i_size == SZ_H ? {{16{~i_unsigned & w_half[15]}}, w_half} : i_rdata;
    // sub-word stores keep the untouched lanes of the word read in RD
    o_mdata = i_size == SZ_B ? (i_rdata & ~w_bmask) | ({24'd0, i_wdata[7:0]} << w_bsh) :
              i_size == SZ_H ? (i_rdata & ~w_hmask) | ({16'd0, i_wdata[15:0]} << w_hsh) : i_wdata;
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-request load/store unit with sub-word read-modify-write stores.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t              r_state;
  logic                r_store;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic                w_err;
  logic [31:0]         w_ldata;
  logic [31:0]         w_mdata;
  assign w_err = misaligned(req_size, req_addr[1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_store      <= 1'b0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_store      <= req_store;
          r_size       <= req_size;
          r_unsigned   <= req_unsigned;
          r_addr       <= req_addr;
          r_wdata      <= req_wdata;
          r_state      <= w_err ? S_RESP : (req_store && req_size == SZ_W) ? S_WR : S_RD;
          r_mem_read   <= !w_err && !(req_store && req_size == SZ_W);
          r_mem_write  <= !w_err && req_store && req_size == SZ_W;
          r_resp_valid <= w_err;
          r_resp_err   <= w_err;
        end
        S_RD: begin
          r_state      <= r_store ? S_WR : S_RESP;
          r_mem_read   <= 1'b0;
          r_mem_write  <= r_store;
          r_resp_valid <= !r_store;
        end
        S_WR: begin
          r_state      <= S_RESP;
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end
  dmem_lsu_align u_align (
    .i_rdata    (mem_rdata),
    .i_wdata    (r_wdata),
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ldata    (w_ldata),
    .o_mdata    (w_mdata)
  );
  assign req_ready  = r_state == S_IDLE;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = (r_resp_valid && !r_store && !r_resp_err) ? w_ldata : 32'd0;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr[ADDR_W+1:2];
  assign mem_wdata  = r_mem_write ? w_mdata : 32'd0;
endmodule
